input_skew_feeder: RTL and testbench

Parametrised input feeder for the systolic array's west or north edge. It buffers one operand tile of ROWS × DEPTH elements, loaded column-by-column through a valid/ready port. It then streams the tile into the array with per-row skew (row r delayed r beats) and a programmable beat pacing that matches the PE/DSP pipeline. It supersedes the per-row fixed-delay shifter with one multi-row block that has handshaking, stall, completion signalling, and optional double buffering.

---
 rtl/systolic_pkg.sv | 15 +
 rtl/skew_row_bank.sv | 30 +++
 rtl/input_skew_feeder.sv | 169 ++++++++++++++++
 tb/tb_input_skew_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge feeders.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

  // Width of a counter or index covering n values, never narrower than one bit.
  function automatic int unsigned sys_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_row_bank.sv
// One row of a feeder operand tile: DEPTH x DATA_W storage with indexed
// write and combinational indexed read.
module skew_row_bank
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_we,
  input  logic [sys_width(DEPTH)-1:0]   i_widx,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic [sys_width(DEPTH)-1:0]   i_ridx,
  output logic [DATA_W-1:0]             o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/input_skew_feeder.sv
// Systolic edge feeder: buffers a ROWS x DEPTH tile loaded column-wise and
// streams it with per-row skew and PACE-cycle beats.
// Define SKEW_FEEDER_DBUF_EN for double buffering (load next tile while streaming).
module input_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PACE   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ROWS*DATA_W-1:0]   s_data,
  input  logic                     start,
  input  logic                     stream_en,
  output logic [ROWS-1:0]          m_valid,
  output logic [ROWS*DATA_W-1:0]   m_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BW = sys_width(DEPTH + ROWS);
  localparam int unsigned PW = sys_width(PACE + 1);
  localparam int unsigned WW = sys_width(DEPTH + 1);
  localparam int unsigned AW = sys_width(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH + ROWS - 2);
  localparam logic [PW-1:0] LAST_PH   = PW'(PACE - 1);
  localparam logic [WW-1:0] LAST_COL  = WW'(DEPTH - 1);
`ifdef SKEW_FEEDER_DBUF_EN
  localparam int unsigned NB   = 2;
  localparam bit          DBUF = 1'b1;
`else
  localparam int unsigned NB   = 1;
  localparam bit          DBUF = 1'b0;
`endif

  feeder_state_t   r_state, w_state_nx;
  logic [BW-1:0]   r_b, w_b_nx;
  logic [PW-1:0]   r_p, w_p_nx;
  logic [WW-1:0]   r_wcnt, w_wcnt_nx;
  logic            r_done, w_done_nx;
  logic            r_wsel, w_wsel_nx;
  logic            r_rsel, w_rsel_nx;
  logic            r_sfull, w_sfull_nx;

  logic            w_load, w_last_col, w_live;
  logic [DATA_W-1:0] w_rd [NB][ROWS];

`ifdef SKEW_FEEDER_DBUF_EN
  assign s_ready = ~rst & ~r_sfull;
`else
  assign s_ready = ~rst & (r_state == IDLE);
`endif

  assign w_load     = s_valid & s_ready;
  assign w_last_col = w_load && (r_wcnt == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_p     <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
      r_wsel  <= 1'b0;
      r_rsel  <= 1'b0;
      r_sfull <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_b     <= w_b_nx;
      r_p     <= w_p_nx;
      r_wcnt  <= w_wcnt_nx;
      r_done  <= w_done_nx;
      r_wsel  <= w_wsel_nx;
      r_rsel  <= w_rsel_nx;
      r_sfull <= w_sfull_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_b_nx     = r_b;
    w_p_nx     = r_p;
    w_wcnt_nx  = r_wcnt;
    w_done_nx  = 1'b0;
    w_wsel_nx  = r_wsel;
    w_rsel_nx  = r_rsel;
    w_sfull_nx = r_sfull;

    if (w_load) begin
      w_wcnt_nx = w_last_col ? '0 : r_wcnt + 1'b1;
      if (w_last_col) w_sfull_nx = 1'b1;
    end

    unique case (r_state)
      IDLE: if (w_last_col) w_state_nx = FULL;
      FULL: begin
        if (start) begin
          w_state_nx = STREAM;
          w_b_nx     = '0;
          w_p_nx     = '0;
          w_rsel_nx  = r_wsel;
          w_wsel_nx  = DBUF ? ~r_wsel : r_wsel;
          w_sfull_nx = 1'b0;
        end
      end
      STREAM: begin
        if (stream_en) begin
          if (r_p == LAST_PH) begin
            w_p_nx = '0;
            if (r_b == LAST_BEAT) begin
              w_done_nx = 1'b1;
              // A full shadow bank with start held restarts without a gap.
              if (DBUF && start && r_sfull) begin
                w_state_nx = STREAM;
                w_b_nx     = '0;
                w_rsel_nx  = r_wsel;
                w_wsel_nx  = ~r_wsel;
                w_sfull_nx = 1'b0;
              end else if (r_sfull || w_last_col) begin
                w_state_nx = FULL;
              end else begin
                w_state_nx = IDLE;
              end
            end else begin
              w_b_nx = r_b + 1'b1;
            end
          end else begin
            w_p_nx = r_p + 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign busy   = (r_state == STREAM);
  assign done   = r_done;
  assign w_live = busy && (r_p == '0) && stream_en;

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [AW-1:0]     w_ridx;
    logic [DATA_W-1:0] w_sel;

    for (genvar k = 0; k < NB; k++) begin : g_bank
      skew_row_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_bank (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_load && (r_wsel == 1'(k))),
        .i_widx  (AW'(r_wcnt)),
        .i_wdata (s_data[g*DATA_W +: DATA_W]),
        .i_ridx  (w_ridx),
        .o_rdata (w_rd[k][g])
      );
    end

    assign w_ridx = AW'(r_b - BW'(g));
    assign w_sel  = (NB == 2 && r_rsel) ? w_rd[NB-1][g] : w_rd[0][g];
    assign m_valid[g] = w_live && (r_b >= BW'(g)) && ((r_b - BW'(g)) < BW'(DEPTH));
    assign m_data[g*DATA_W +: DATA_W] = m_valid[g] ? w_sel : '0;
  end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder: table-driven stream checks plus
// hand-written reset, stall, pacing and (SKEW_FEEDER_DBUF_EN) back-to-back cases.
module tb_input_skew_feeder;
  localparam int unsigned DW = 16;
  localparam int unsigned R  = 4;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, s_valid, start, stream_en, s_ready, busy, done;
  logic [R-1:0]   m_valid;
  logic [R*DW-1:0] s_data, m_data;
  logic           s_valid3, start3, en3, s_ready3, busy3, done3;
  logic [R-1:0]   m_valid3;
  logic [R*DW-1:0] m_data3;

  input_skew_feeder #(.DATA_W(DW), .ROWS(R), .DEPTH(D), .PACE(1)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .start(start), .stream_en(stream_en), .m_valid(m_valid), .m_data(m_data),
    .busy(busy), .done(done)
  );

  input_skew_feeder #(.DATA_W(DW), .ROWS(R), .DEPTH(D), .PACE(3)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data),
    .start(start3), .stream_en(en3), .m_valid(m_valid3), .m_data(m_data3),
    .busy(busy3), .done(done3)
  );

  typedef struct {
    bit              en;
    logic [R-1:0]    v;
    logic [R*DW-1:0] d;
    bit              busy;
    bit              done;
  } vec_t;

  vec_t basic [8];
  vec_t stall [13];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [R*DW-1:0] col(input int unsigned k, input logic [15:0] base);
    logic [R*DW-1:0] c;
    for (int unsigned r = 0; r < R; r++) c[r*DW +: DW] = base + 16'(16'h10 * r + k);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cols(input logic [15:0] base, input int unsigned k0, input int unsigned k1);
    for (int unsigned k = k0; k <= k1; k++) begin
      s_valid = 1'b1;
      s_data  = col(k, base);
      #1;
      chk("load_ready", 128'(s_ready), 128'(1'b1));
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply(input string name, input vec_t v);
    stream_en = v.en;
    #1;
    chk(name, 128'({busy, done, m_valid, m_data}), 128'({v.busy, v.done, v.v, v.d}));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    basic[0] = '{1'b1, 4'b0001, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    basic[1] = '{1'b1, 4'b0011, 64'h0000_0000_0010_0001, 1'b1, 1'b0};
    basic[2] = '{1'b1, 4'b0111, 64'h0000_0020_0011_0002, 1'b1, 1'b0};
    basic[3] = '{1'b1, 4'b1111, 64'h0030_0021_0012_0003, 1'b1, 1'b0};
    basic[4] = '{1'b1, 4'b1110, 64'h0031_0022_0013_0000, 1'b1, 1'b0};
    basic[5] = '{1'b1, 4'b1100, 64'h0032_0023_0000_0000, 1'b1, 1'b0};
    basic[6] = '{1'b1, 4'b1000, 64'h0033_0000_0000_0000, 1'b1, 1'b0};
    basic[7] = '{1'b1, 4'b0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1};
    stall[0] = basic[0];
    stall[1] = basic[1];
    for (int i = 2; i < 7; i++) stall[i] = '{1'b0, 4'b0000, 64'h0, 1'b1, 1'b0};
    for (int i = 7; i < 13; i++) stall[i] = basic[i-5];

    rst = 1'b1; s_valid = 1'b0; start = 1'b0; stream_en = 1'b0; s_data = '0;
    s_valid3 = 1'b0; start3 = 1'b0; en3 = 1'b0;
    #2;
    chk("reset_s_ready", 128'(s_ready), 128'(1'b0));
    chk("reset_outputs", 128'({busy, done, m_valid, m_data}), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("idle_s_ready", 128'(s_ready), 128'(1'b1));
    chk("idle_outputs", 128'({busy, done, m_valid, m_data}), 128'(0));

    // Partial bank: start must be ignored.
    load_cols(16'h0000, 0, 1);
    pulse_start();
    #1;
    chk("illegal_start_busy", 128'({busy, s_ready}), 128'(2'b01));
    tick();
    load_cols(16'h0000, 2, 3);
    #1;
    chk("full_busy", 128'(busy), 128'(1'b0));
`ifndef SKEW_FEEDER_DBUF_EN
    chk("full_s_ready", 128'(s_ready), 128'(1'b0));
`endif

    stream_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
`ifndef SKEW_FEEDER_DBUF_EN
      if (i == 3) chk("stream_s_ready", 128'(s_ready), 128'(1'b0));
`endif
      apply($sformatf("basic_beat%0d", i), basic[i]);
    end
    #1;
    chk("done_one_cycle", 128'({busy, done}), 128'(2'b00));

    // Stall at beat 2 for 5 cycles.
    load_cols(16'h0000, 0, 3);
    stream_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 13; i++) apply($sformatf("stall_cyc%0d", i), stall[i]);

    // Reset at beat 3.
    load_cols(16'h0000, 0, 3);
    stream_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) apply($sformatf("rst_pre_beat%0d", i), basic[i]);
    #1;
    chk("rst_pre_beat3", 128'({busy, done, m_valid, m_data}), 128'({1'b1, 1'b0, basic[3].v, basic[3].d}));
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 128'({s_ready, busy, done, m_valid, m_data}), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release", 128'({s_ready, busy}), 128'(2'b10));
    load_cols(16'h0100, 0, 3);
    #1;
    chk("rst_wcnt_zero_full", 128'(busy), 128'(1'b0));
`ifndef SKEW_FEEDER_DBUF_EN
    chk("rst_wcnt_zero_ready", 128'(s_ready), 128'(1'b0));
`endif
    pulse_start();
    #1;
    chk("rst_new_beat0", 128'({busy, done, m_valid, m_data}), 128'({1'b1, 1'b0, 4'b0001, 64'h0000_0000_0000_0100}));
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("rst_new_done", 128'({busy, done}), 128'(2'b01));
    tick();

    // PACE=3 instance: beats every third cycle.
    for (int unsigned k = 0; k < D; k++) begin
      s_valid3 = 1'b1;
      s_data   = col(k, 16'h0000);
      tick();
    end
    s_valid3 = 1'b0;
    en3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 21; c++) begin
      #1;
      if (c % 3 == 0)
        chk($sformatf("pace_cyc%0d", c), 128'({busy3, done3, m_valid3, m_data3}),
            128'({1'b1, 1'b0, basic[c/3].v, basic[c/3].d}));
      else
        chk($sformatf("pace_cyc%0d", c), 128'({busy3, done3, m_valid3, m_data3}),
            128'({1'b1, 1'b0, 4'b0000, 64'h0}));
      tick();
    end
    #1;
    chk("pace_done", 128'({busy3, done3, m_valid3}), 128'({1'b0, 1'b1, 4'b0000}));
    tick();

`ifdef SKEW_FEEDER_DBUF_EN
    // Back-to-back tiles: B loads during A, start held from beat 4.
    load_cols(16'h0000, 0, 3);
    stream_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        s_valid = 1'b1;
        s_data  = col(i, 16'h0200);
        #1;
        chk("dbuf_load_ready", 128'(s_ready), 128'(1'b1));
      end else begin
        s_valid = 1'b0;
        start   = 1'b1;
        #1;
      end
      chk($sformatf("dbuf_a_beat%0d", i), 128'({busy, done, m_valid, m_data}),
          128'({1'b1, 1'b0, basic[i].v, basic[i].d}));
      tick();
    end
    start = 1'b0;
    #1;
    chk("dbuf_b_beat0", 128'({busy, done, m_valid, m_data}), 128'({1'b1, 1'b1, 4'b0001, 64'h0000_0000_0000_0200}));
    tick();
    chk("dbuf_b_beat1", 128'({busy, done, m_valid, m_data}), 128'({1'b1, 1'b0, 4'b0011, 64'h0000_0000_0210_0201}));
    for (int i = 0; i < 6; i++) tick();
    chk("dbuf_b_done", 128'({busy, done}), 128'(2'b01));
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
